// File: rtl/occ_gtpe2_pkg.sv
// Shared definitions for the GTPE2 reset sequencer.
// Contents: state encoding, tile control bundle, small constant helper.
package occ_gtpe2_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST     = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_TX_RST      = 3'd2,
    ST_WAIT_TXDONE = 3'd3,
    ST_RX_RST      = 3'd4,
    ST_WAIT_RXDONE = 3'd5,
    ST_READY       = 3'd6,
    ST_FAIL        = 3'd7
  } state_e;

  // Everything the sequencer drives towards the tile and the link status flags.
  typedef struct packed {
    logic pll_rst;
    logic txreset;
    logic rxreset;
    logic txuserrdy;
    logic rxuserrdy;
    logic rxencommaalign;
    logic ready;
    logic fail;
  } tile_ctrl_t;

  // All tile resets asserted, every enable and flag low.
  localparam tile_ctrl_t CTRL_RESET = 8'b1110_0000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/occ_gtpe2_reset_sync.sv
// Multi-bit two-stage synchronizer with synchronous active-high clear.
// Ports: clk - destination clock; rst - clears both stages;
//        din - asynchronous inputs; dout - synchronized outputs (2-cycle latency).
module occ_gtpe2_reset_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;

  // Bits are independent status levels, so per-bit synchronization is enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      dout   <= '0;
    end else begin
      meta_q <= din;
      dout   <= meta_q;
    end
  end

endmodule

// File: rtl/occ_gtpe2_reset_seq.sv
// GTPE2 reset sequencer: PLL reset, lock wait, TX reset/done, RX reset/done,
// then link ready, with per-state timeouts, bounded retries and a fail state.
// Ports: init_clk_i/init_rst_i - clock and synchronous active-high reset;
//        soft_rst_i - one-cycle restart pulse, also clears the retry count;
//        pll_lock_i, txresetdone_i, rxresetdone_i - asynchronous tile status;
//        pll_rst_o, txreset_o, rxreset_o - tile resets;
//        txuserrdy_o, rxuserrdy_o, rxencommaalign_o - tile enables;
//        ready_o, fail_o - link up / permanent failure;
//        state_o - current state code; retries_o - retries used so far.
module occ_gtpe2_reset_seq
  import occ_gtpe2_pkg::*;
#(
  parameter int unsigned g_PLL_RST_CYCLES = 200,
  parameter int unsigned g_GT_RST_CYCLES  = 4,
  parameter int unsigned g_TIMEOUT_CYCLES = 65535,
  parameter int unsigned g_MAX_RETRIES    = 3
) (
  input  logic               init_clk_i,
  input  logic               init_rst_i,
  input  logic               soft_rst_i,
  input  logic               pll_lock_i,
  input  logic               txresetdone_i,
  input  logic               rxresetdone_i,
  output logic               pll_rst_o,
  output logic               txreset_o,
  output logic               rxreset_o,
  output logic               txuserrdy_o,
  output logic               rxuserrdy_o,
  output logic               rxencommaalign_o,
  output logic               ready_o,
  output logic               fail_o,
  output logic [STATE_W-1:0] state_o,
  output logic [1:0]         retries_o
);

  // The counter also times the fixed reset pulses, so it must reach the longest
  // of them even when the timeout is configured shorter; with default
  // parameters this is exactly the timeout width.
  localparam int unsigned CNT_MAX = max_u(max_u(g_TIMEOUT_CYCLES, g_PLL_RST_CYCLES),
                                          g_GT_RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(g_PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(g_GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(g_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] READY_CLR = CNT_W'(g_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(g_MAX_RETRIES);

  logic [2:0]       status_s;
  logic             lock_s;
  logic             txdone_s;
  logic             rxdone_s;
  state_e           state_q;
  state_e           state_d;
  logic [1:0]       retries_q;
  logic [1:0]       retries_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             do_retry;
  tile_ctrl_t       ctrl_q;
  tile_ctrl_t       ctrl_d;

  occ_gtpe2_reset_sync #(
    .WIDTH (3)
  ) u_sync (
    .clk  (init_clk_i),
    .rst  (init_rst_i),
    .din  ({pll_lock_i, txresetdone_i, rxresetdone_i}),
    .dout (status_s)
  );

  assign {lock_s, txdone_s, rxdone_s} = status_s;
  assign timeout = (cnt_q == TMO);

  // State, retry count, cycle counter and registered outputs.
  always_ff @(posedge init_clk_i) begin
    if (init_rst_i) begin
      state_q   <= ST_PLL_RST;
      retries_q <= '0;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_RESET;
    end else begin
      state_q   <= state_d;
      retries_q <= retries_d;
      ctrl_q    <= ctrl_d;
      // Restart timing on every state change, including a soft restart of PLL_RST.
      if ((state_d != state_q) || soft_rst_i) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state and retry bookkeeping.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    do_retry  = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)       state_d  = ST_TX_RST;
        else if (timeout) do_retry = 1'b1;
      end
      ST_TX_RST: begin
        if (cnt_q == GT_LAST) state_d = ST_WAIT_TXDONE;
      end
      ST_WAIT_TXDONE: begin
        if (!lock_s)       do_retry = 1'b1;
        else if (txdone_s) state_d  = ST_RX_RST;
        else if (timeout)  do_retry = 1'b1;
      end
      ST_RX_RST: begin
        if (cnt_q == GT_LAST) state_d = ST_WAIT_RXDONE;
      end
      ST_WAIT_RXDONE: begin
        if (!lock_s)       do_retry = 1'b1;
        else if (rxdone_s) state_d  = ST_READY;
        else if (timeout)  do_retry = 1'b1;
      end
      ST_READY: begin
        // A lost lock needs the whole bring-up; a lost done only its own half.
        if (!lock_s)                 do_retry  = 1'b1;
        else if (!txdone_s)          state_d   = ST_TX_RST;
        else if (!rxdone_s)          state_d   = ST_RX_RST;
        else if (cnt_q >= READY_CLR) retries_d = '0;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    if (do_retry) begin
      if (retries_q < RETRY_MAX) begin
        state_d   = ST_PLL_RST;
        retries_d = retries_q + 2'd1;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (soft_rst_i) begin
      state_d   = ST_PLL_RST;
      retries_d = '0;
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_PLL_RST: begin
        ctrl_d.pll_rst = 1'b1;
        ctrl_d.txreset = 1'b1;
        ctrl_d.rxreset = 1'b1;
      end
      ST_WAIT_LOCK: begin
        ctrl_d = '0;
      end
      ST_TX_RST: begin
        ctrl_d.txreset = 1'b1;
      end
      ST_WAIT_TXDONE: begin
        ctrl_d.txuserrdy = 1'b1;
      end
      ST_RX_RST: begin
        ctrl_d.txuserrdy = 1'b1;
        ctrl_d.rxreset   = 1'b1;
      end
      ST_WAIT_RXDONE: begin
        ctrl_d.txuserrdy = 1'b1;
        ctrl_d.rxuserrdy = 1'b1;
      end
      ST_READY: begin
        ctrl_d.txuserrdy      = 1'b1;
        ctrl_d.rxuserrdy      = 1'b1;
        ctrl_d.rxencommaalign = 1'b1;
        ctrl_d.ready          = 1'b1;
      end
      ST_FAIL: begin
        ctrl_d.fail    = 1'b1;
        ctrl_d.pll_rst = 1'b1;
        ctrl_d.txreset = 1'b1;
        ctrl_d.rxreset = 1'b1;
      end
      default: begin
        ctrl_d = CTRL_RESET;
      end
    endcase
  end

  assign pll_rst_o        = ctrl_q.pll_rst;
  assign txreset_o        = ctrl_q.txreset;
  assign rxreset_o        = ctrl_q.rxreset;
  assign txuserrdy_o      = ctrl_q.txuserrdy;
  assign rxuserrdy_o      = ctrl_q.rxuserrdy;
  assign rxencommaalign_o = ctrl_q.rxencommaalign;
  assign ready_o          = ctrl_q.ready;
  assign fail_o           = ctrl_q.fail;
  assign state_o          = STATE_W'(state_q);
  assign retries_o        = retries_q;

endmodule
